// File: rtl/mux_arb_reg.sv
// -----------------------------------------------------------------------------
// mux_arb_reg
//   Parametrised NUM_IN-input, WIDTH-bit registered channel selector with
//   per-input valid/ready handshakes and one output register stage.
//   The winning channel is picked in one of two ways:
//     mode = 0 : fixed select, using the channel index on sel
//     mode = 1 : round-robin, scanning from the channel after the last winner
//
// Ports
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous reset, active-high
//   in_data    in   NUM_IN*WIDTH  channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   NUM_IN        channel i offers a word
//   in_ready   out  NUM_IN        channel i word accepted this cycle (one-hot/zero)
//   mode       in   1             0 = fixed select, 1 = round-robin
//   sel        in   SEL_W         channel index used in mode 0
//   out_data   out  WIDTH         registered selected word
//   out_src    out  SEL_W         channel index that out_data came from
//   out_valid  out  1             out_data/out_src hold an undelivered word
//   out_ready  in   1             consumer accepts the word this cycle
//   xfer_count out  32            delivered-word counter (MUX_ARB_STATS_EN only)
//
// Build option
//   MUX_ARB_STATS_EN : when defined, adds xfer_count, which counts every
//                      cycle with out_valid && out_ready and wraps at 2^32.
// -----------------------------------------------------------------------------
module mux_arb_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [31:0]             xfer_count
`endif
);

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_src_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] rr_ptr_reg;

    logic             load_en;
    logic             grant;
    logic [SEL_W-1:0] winner;
    logic [WIDTH-1:0] win_data;
    int               rr_idx;

    logic [WIDTH-1:0] ch_data [NUM_IN];

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = load_en && grant && (winner == SEL_W'(gi));
        end
    endgenerate

    // The stage can take a new word when empty or when its current word
    // leaves on this same edge.
    assign load_en = !out_valid_reg || out_ready;

    // Winner selection. Comparing sel against every legal index (rather
    // than indexing in_valid with sel) makes sel >= NUM_IN a clean no-grant.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        rr_idx = 0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant  = 1'b1;
                    winner = sel;
                end
            end
        end else begin
            // Scan rr_ptr+1 .. rr_ptr+NUM_IN, wrapping mod NUM_IN (not 2^SEL_W)
            for (int k = 1; k <= NUM_IN; k++) begin
                rr_idx = (int'(rr_ptr_reg) + k) % NUM_IN;
                if (!grant && in_valid[rr_idx]) begin
                    grant  = 1'b1;
                    winner = SEL_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (winner == SEL_W'(i)) begin
                win_data = ch_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= SEL_W'(NUM_IN - 1);
        end else if (load_en) begin
            if (grant) begin
                out_data_reg  <= win_data;
                out_src_reg   <= winner;
                out_valid_reg <= 1'b1;
                if (mode) begin
                    rr_ptr_reg <= winner;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_valid = out_valid_reg;

`ifdef MUX_ARB_STATS_EN
    logic [31:0] xfer_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            xfer_count_reg <= xfer_count_reg + 32'd1;
        end
    end

    assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_reg
//   Self-checking bench for mux_arb_reg (WIDTH=32, NUM_IN=8, SEL_W=3).
//   A table of directed vectors walks through fixed-select and round-robin
//   cases; hand-written sequences cover sustained round-robin, stalls,
//   asynchronous reset and (with MUX_ARB_STATS_EN) the transfer counter.
// -----------------------------------------------------------------------------
module tb_mux_arb_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] in_data;
    logic [7:0]   in_valid;
    logic [7:0]   in_ready;
    logic         mode;
    logic [2:0]   sel;
    logic [31:0]  out_data;
    logic [2:0]   out_src;
    logic         out_valid;
    logic         out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [31:0]  xfer_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_arb_reg #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    typedef struct {
        logic        mode;
        logic [2:0]  sel;
        logic [7:0]  iv;
        logic        ordy;
        logic [7:0]  rdy;   // expected in_ready before the edge
        logic        ov;    // expected out_valid after the edge
        logic [2:0]  src;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [31:0] chword(input int i);
        if (i == 3) return 32'hDEADBEEF;
        return 32'hC0DE_0000 + i;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mode = 1'b0; sel = 3'd0; in_valid = 8'h00; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive at negedge, check combinational ready, then check registers after the edge
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        mode = v.mode; sel = v.sel; in_valid = v.iv; out_ready = v.ordy;
        #1;
        check({tag, " in_ready"}, {24'd0, in_ready}, {24'd0, v.rdy});
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.ov});
        check({tag, " out_src"}, {29'd0, out_src}, {29'd0, v.src});
        check({tag, " out_data"}, out_data, v.data);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        mode = 1'b0; sel = 3'd0; in_valid = 8'h00; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = chword(i);

        //              mode sel   iv     ordy  rdy    ov    src   data
        tbl[0]  = '{1'b0, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'd5, 8'h08, 1'b1, 8'h00, 1'b0, 3'd3, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 3'd7, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 32'hC0DE0007};
        tbl[3]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 32'hC0DE0000};
        tbl[4]  = '{1'b1, 3'd0, 8'h24, 1'b1, 8'h04, 1'b1, 3'd2, 32'hC0DE0002};
        tbl[5]  = '{1'b1, 3'd0, 8'h24, 1'b0, 8'h00, 1'b1, 3'd2, 32'hC0DE0002};
        tbl[6]  = '{1'b1, 3'd0, 8'h24, 1'b1, 8'h20, 1'b1, 3'd5, 32'hC0DE0005};
        tbl[7]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 32'hC0DE0005};
        tbl[8]  = '{1'b1, 3'd0, 8'h24, 1'b0, 8'h04, 1'b1, 3'd2, 32'hC0DE0002};
        tbl[9]  = '{1'b0, 3'd2, 8'h04, 1'b0, 8'h00, 1'b1, 3'd2, 32'hC0DE0002};
        tbl[10] = '{1'b0, 3'd0, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 32'hC0DE0000};
        tbl[11] = '{1'b1, 3'd0, 8'h0C, 1'b1, 8'h08, 1'b1, 3'd3, 32'hDEADBEEF};
        tbl[12] = '{1'b1, 3'd0, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2, 32'hC0DE0002};
        tbl[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 32'hC0DE0002};

        // Reset state
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset out_src", {29'd0, out_src}, 32'd0);
        check("reset in_ready", {24'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Sustained round-robin, all channels valid: 0..7 then 0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            v = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01 << (k % 8), 1'b1, 3'(k % 8), chword(k % 8)};
            apply(v, $sformatf("rr_all%0d", k));
        end

        // Stall with channels 0 and 7 valid, then alternate 7,0,7,0
        do_reset();
        apply('{1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 32'hC0DE0000}, "stall_load");
        for (int k = 0; k < 3; k++)
            apply('{1'b1, 3'd0, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 32'hC0DE0000},
                  $sformatf("stall%0d", k));
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                apply('{1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 32'hC0DE0007},
                      $sformatf("alt%0d", k));
            else
                apply('{1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 32'hC0DE0000},
                      $sformatf("alt%0d", k));
        end

        // Asynchronous reset while a word is held
        do_reset();
        apply('{1'b0, 3'd1, 8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 32'hC0DE0001}, "arst_load");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst out_valid", {31'd0, out_valid}, 32'd0);
        check("arst out_data", out_data, 32'd0);
        check("arst out_src", {29'd0, out_src}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply('{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 32'hC0DE0000}, "arst_rr_first");

`ifdef MUX_ARB_STATS_EN
        // 10 transfers with 2 stall cycles interleaved
        do_reset();
        check("stats reset", xfer_count, 32'd0);
        apply('{1'b0, 3'd1, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 32'hC0DE0001}, "stats_load");
        for (int k = 0; k < 12; k++) begin
            if (k == 3 || k == 8)
                apply('{1'b0, 3'd1, 8'h02, 1'b0, 8'h00, 1'b1, 3'd1, 32'hC0DE0001},
                      $sformatf("stats_stall%0d", k));
            else
                apply('{1'b0, 3'd1, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 32'hC0DE0001},
                      $sformatf("stats_xfer%0d", k));
        end
        check("stats count10", xfer_count, 32'd10);
        // Counter wrap
        @(negedge clk);
        out_ready = 1'b0;
        force dut.xfer_count_reg = 32'hFFFFFFFF;
        #1;
        release dut.xfer_count_reg;
        apply('{1'b0, 3'd1, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 32'hC0DE0001}, "wrap_xfer0");
        check("stats wrap0", xfer_count, 32'd0);
        apply('{1'b0, 3'd1, 8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 32'hC0DE0001}, "wrap_xfer1");
        check("stats wrap1", xfer_count, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
